pmem_responder: RTL

- Synthesizable responder for the physical-memory side of the cache hierarchy: it services `pmem_read`/`pmem_write` requests issued by the eviction write buffer.
- Holds a line-granular backing store and returns `pmem_resp` after a programmable latency.
- Serves as the memory model for top-level simulation and for FPGA bring-up without external DRAM.
- Includes a protocol checker and saturating request counters for debug.

---
 rtl/pmem_responder.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/pmem_responder.sv
// ---------------------------------------------------------------------------
// pmem_responder
//   Line-granular physical-memory model. It services pmem_read/pmem_write
//   requests from the eviction write buffer. Each request completes with a
//   one-cycle pmem_resp pulse after a programmable latency. The block also
//   flags protocol violations and keeps saturating completion counters.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset (storage array not reset)
//   pmem_read     read request, held high until pmem_resp
//   pmem_write    write request, held high until pmem_resp
//   pmem_address  byte address; only the line-index bits select storage
//   pmem_wdata    write line data
//   pmem_resp     one-cycle completion pulse
//   pmem_rdata    last read line, updated when a read completes
//   proto_err     sticky protocol-violation flag
//   rd_count      saturating count of completed reads
//   wr_count      saturating count of completed writes
//
// Optional build macro
//   PMEM_RESP_JITTER_EN : adds 0..3 cycles of LFSR-driven latency jitter.
// ---------------------------------------------------------------------------
module pmem_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_BITS  = 256,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [ADDR_WIDTH-1:0] pmem_address,
  input  logic [LINE_BITS-1:0]  pmem_wdata,
  output logic                  pmem_resp,
  output logic [LINE_BITS-1:0]  pmem_rdata,
  output logic                  proto_err,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);

  localparam int OFF   = $clog2(LINE_BITS / 8);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  // Nine bits cover LATENCY-1 up to 254 plus up to 3 cycles of jitter.
  localparam int CNT_W = 9;
  localparam logic [CNT_W-1:0] LOAD_BASE = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic                    op_wr_r;
  logic [ADDR_WIDTH-1:0]   cap_addr_r;
  logic [LINE_BITS-1:0]    cap_wdata_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [CNT_W-1:0]        load_s;
  logic                    resp_r;
  logic [LINE_BITS-1:0]    rdata_r;
  logic                    err_r;
  logic [15:0]             rd_cnt_r;
  logic [15:0]             wr_cnt_r;
  logic [LINE_BITS-1:0]    mem_r [DEPTH];

  logic [DEPTH_LOG2-1:0]   index_s;
  logic                    own_req_s;
  logic                    other_req_s;
  logic                    addr_moved_s;
  logic                    accept_s;
  logic                    collide_s;
  logic                    dec_s;
  logic                    last_s;
  logic                    rd_load_s;
  logic                    done_rd_s;
  logic                    done_wr_s;
  logic                    viol_s;

  // Upper address bits are dropped here, so lines alias modulo DEPTH.
  assign index_s      = cap_addr_r[OFF+DEPTH_LOG2-1:OFF];
  assign own_req_s    = op_wr_r ? pmem_write : pmem_read;
  assign other_req_s  = op_wr_r ? pmem_read  : pmem_write;
  assign addr_moved_s = (pmem_address != cap_addr_r);

`ifdef PMEM_RESP_JITTER_EN
  logic [15:0] lfsr_r;
  logic        lfsr_fb_s;

  assign lfsr_fb_s = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
  assign load_s    = LOAD_BASE + {{(CNT_W-2){1'b0}}, lfsr_r[1:0]};

  // Free-running Fibonacci LFSR (taps 16,14,13,11) supplying latency jitter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= 16'hACE1;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_fb_s};
    end
  end
`else
  assign load_s = LOAD_BASE;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; RESP always returns to IDLE so no request is
  // accepted in the same cycle as the response pulse.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (pmem_read ^ pmem_write) state_s = BUSY;
        else                        state_s = IDLE;
      end
      BUSY: begin
        if (cnt_r == CNT_ZERO) state_s = RESP;
        else                   state_s = BUSY;
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM output decode: datapath strobes and protocol-violation detection.
  always_comb begin
    accept_s  = 1'b0;
    collide_s = 1'b0;
    dec_s     = 1'b0;
    last_s    = 1'b0;
    rd_load_s = 1'b0;
    done_rd_s = 1'b0;
    done_wr_s = 1'b0;
    viol_s    = 1'b0;
    case (state_r)
      IDLE: begin
        accept_s  = pmem_read ^ pmem_write;
        collide_s = pmem_read & pmem_write;
      end
      BUSY: begin
        if (cnt_r == CNT_ZERO) begin
          last_s    = 1'b1;
          rd_load_s = ~op_wr_r;
        end else begin
          dec_s = 1'b1;
        end
        viol_s = ~own_req_s | other_req_s | addr_moved_s;
      end
      RESP: begin
        // The requester may drop its request on the resp edge, so only
        // the opposite op and the address are checked here.
        done_wr_s = op_wr_r;
        done_rd_s = ~op_wr_r;
        viol_s    = other_req_s | addr_moved_s;
      end
      default: begin
        accept_s = 1'b0;
      end
    endcase
  end

  // Request capture, latency counter, registered outputs and debug counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_wr_r     <= 1'b0;
      cap_addr_r  <= {ADDR_WIDTH{1'b0}};
      cap_wdata_r <= {LINE_BITS{1'b0}};
      cnt_r       <= CNT_ZERO;
      resp_r      <= 1'b0;
      rdata_r     <= {LINE_BITS{1'b0}};
      err_r       <= 1'b0;
      rd_cnt_r    <= 16'h0000;
      wr_cnt_r    <= 16'h0000;
    end else begin
      if (accept_s) begin
        op_wr_r     <= pmem_write;
        cap_addr_r  <= pmem_address;
        cap_wdata_r <= pmem_wdata;
        cnt_r       <= load_s;
      end else if (dec_s) begin
        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end
      resp_r <= last_s;
      if (rd_load_s) rdata_r <= mem_r[index_s];
      if (collide_s || viol_s) err_r <= 1'b1;
      if (done_rd_s && (rd_cnt_r != 16'hFFFF)) rd_cnt_r <= rd_cnt_r + 16'd1;
      if (done_wr_s && (wr_cnt_r != 16'hFFFF)) wr_cnt_r <= wr_cnt_r + 16'd1;
    end
  end

  // Backing store; a write commits at the end of RESP so a following read
  // always observes it. A reset drops the FSM out of RESP, so no write occurs.
  always_ff @(posedge clk) begin
    if (done_wr_s) mem_r[index_s] <= cap_wdata_r;
  end

  assign pmem_resp  = resp_r;
  assign pmem_rdata = rdata_r;
  assign proto_err  = err_r;
  assign rd_count   = rd_cnt_r;
  assign wr_count   = wr_cnt_r;

endmodule
